// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: issues one read at a time to instruction memory and
// buffers returned words with their PC in a small FIFO for decode.
module inst_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int PC_STEP    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] next_pc,
  output logic              pc_update,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              misalign_err
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t state;

  logic [ADDR_W-1:0] pendingPc;
  logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifoPc [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic              credit;
  logic              aligned;
  logic              push;
  logic              pop;

  assign next_pc   = fetch_addr + ADDR_W'(PC_STEP);
  assign aligned   = (fetch_addr[1:0] == 2'b00);
  // An outstanding read holds a slot so its returning word always has room.
  assign credit    = (count + CNT_W'(state == WAIT)) < DEPTH_C;
  assign mem_req   = (state == REQ);
  assign pc_update = (state == REQ) && mem_gnt && !flush;
  assign push      = (state == WAIT) && mem_rvalid && !flush;
  assign pop       = inst_valid && inst_ready && !flush;

  assign inst_valid = (count != '0);
  assign inst_data  = fifoData[rdPtr];
  assign inst_pc    = fifoPc[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_addr     <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!aligned) begin
            misalign_err <= 1'b1;
          end else if (credit && !flush && !misalign_err) begin
            mem_addr <= fetch_addr;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) state <= flush ? DROP : WAIT;
          else if (flush) state <= IDLE;
        end
        WAIT: begin
          if (mem_rvalid) state <= IDLE;
          else if (flush) state <= DROP;
        end
        DROP: begin
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REQ && mem_gnt) pendingPc <= mem_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoData[i] <= '0;
        fifoPc[i]   <= '0;
      end
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifoData[wrPtr] <= mem_rdata;
        fifoPc[wrPtr]   <= pendingPc;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: cycle-by-cycle vector table plus
// hand-written backpressure and reset-in-flight sequences.
module tb_inst_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic [31:0] next_pc;
  logic        pc_update;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic        misalign_err;

  inst_fetch_unit #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .next_pc(next_pc),
    .pc_update(pc_update), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .flush(flush), .inst_valid(inst_valid), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstBefore;
    logic [31:0] fa;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        ready, fl;
    logic        expReq, expUpd, expValid, expErr;
    logic [31:0] expAddr, expNext, expPc, expData;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int total = 0;
  int bad = 0;

  logic        gntPrev, pcAdv, seenReq;
  logic [31:0] gntAddr, pcNext, reqAddr;
  logic [31:0] popPc [2];
  logic [31:0] popData [2];
  int          grants, nPop;

  function automatic vec_t mk(input logic rb, input logic [31:0] fa, input logic gnt, input logic rv,
                              input logic [31:0] rd, input logic rdy, input logic fl, input logic eReq,
                              input logic eUpd, input logic eVal, input logic eErr, input logic [31:0] eAddr,
                              input logic [31:0] eNext, input logic [31:0] ePc, input logic [31:0] eData);
    vec_t r;
    r.rstBefore = rb; r.fa = fa; r.gnt = gnt; r.rvalid = rv; r.rdata = rd; r.ready = rdy; r.fl = fl;
    r.expReq = eReq; r.expUpd = eUpd; r.expValid = eVal; r.expErr = eErr;
    r.expAddr = eAddr; r.expNext = eNext; r.expPc = ePc; r.expData = eData;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset(input logic [31:0] fa);
    @(negedge clk);
    rst = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0; inst_ready = 1'b1;
    fetch_addr = fa;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Memory that grants every request at once and returns data the next cycle,
  // plus a PC register that loads next_pc on pc_update.
  task automatic autoStep(input logic rdy);
    @(negedge clk);
    if (pcAdv) fetch_addr = pcNext;
    mem_rvalid = gntPrev;
    mem_rdata  = 32'hA5A50000 | gntAddr;
    mem_gnt    = mem_req;
    inst_ready = rdy;
    flush      = 1'b0;
    #1;
    gntPrev = mem_gnt;
    if (mem_gnt) begin
      gntAddr = mem_addr;
      grants++;
    end
    pcAdv  = pc_update;
    pcNext = next_pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // sequential fetch from 0x0, one-cycle gnt and rvalid
    vecs.push_back(mk(1, 32'h0, 0,0,32'h0,          1,0, 0,0,0,0, 32'h0, 32'h4,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0, 1,0,32'h0,          1,0, 1,1,0,0, 32'h0, 32'h4,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h4, 0,1,32'hA5A50000,   1,0, 0,0,0,0, 32'h0, 32'h8,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h4, 0,0,32'h0,          1,0, 0,0,1,0, 32'h0, 32'h8,  32'h0, 32'hA5A50000));
    vecs.push_back(mk(0, 32'h4, 1,0,32'h0,          1,0, 1,1,0,0, 32'h4, 32'h8,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h8, 0,1,32'hA5A50004,   1,0, 0,0,0,0, 32'h4, 32'hC,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h8, 0,0,32'h0,          1,0, 0,0,1,0, 32'h4, 32'hC,  32'h4, 32'hA5A50004));
    vecs.push_back(mk(0, 32'h8, 1,0,32'h0,          1,0, 1,1,0,0, 32'h8, 32'hC,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'hC, 0,1,32'hA5A50008,   1,0, 0,0,0,0, 32'h8, 32'h10, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'hC, 0,0,32'h0,          1,0, 0,0,1,0, 32'h8, 32'h10, 32'h8, 32'hA5A50008));
    // flush in WAIT, late response discarded, refetch at redirect target
    vecs.push_back(mk(1, 32'h10,  0,0,32'h0,        1,0, 0,0,0,0, 32'h0,   32'h14,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h10,  1,0,32'h0,        1,0, 1,1,0,0, 32'h10,  32'h14,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h100, 0,0,32'h0,        1,1, 0,0,0,0, 32'h10,  32'h104, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h100, 0,0,32'h0,        1,0, 0,0,0,0, 32'h10,  32'h104, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h100, 0,0,32'h0,        1,0, 0,0,0,0, 32'h10,  32'h104, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h100, 0,1,32'hDEADBEEF, 1,0, 0,0,0,0, 32'h10,  32'h104, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h100, 0,0,32'h0,        1,0, 0,0,0,0, 32'h10,  32'h104, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h100, 0,0,32'h0,        1,0, 1,0,0,0, 32'h100, 32'h104, 32'h0, 32'h0));
    // flush coincident with gnt: no pc_update, response dropped
    vecs.push_back(mk(1, 32'h20,  0,0,32'h0,        1,0, 0,0,0,0, 32'h0,   32'h24,  32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h200, 1,0,32'h0,        1,1, 1,0,0,0, 32'h20,  32'h204, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h200, 0,1,32'h11111111, 1,0, 0,0,0,0, 32'h20,  32'h204, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h200, 0,0,32'h0,        1,0, 0,0,0,0, 32'h20,  32'h204, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h200, 0,0,32'h0,        1,0, 1,0,0,0, 32'h200, 32'h204, 32'h0, 32'h0));
    // PC wrap at the top of the address space
    vecs.push_back(mk(1, 32'hFFFFFFFC, 0,0,32'h0,      1,0, 0,0,0,0, 32'h0,        32'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 32'hFFFFFFFC, 1,0,32'h0,      1,0, 1,1,0,0, 32'hFFFFFFFC, 32'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 32'h0,        0,1,32'h12345678,1,0, 0,0,0,0, 32'hFFFFFFFC, 32'h4, 32'h0,        32'h0));
    vecs.push_back(mk(0, 32'h0,        0,0,32'h0,      1,0, 0,0,1,0, 32'hFFFFFFFC, 32'h4, 32'hFFFFFFFC, 32'h12345678));
    // misaligned PC: sticky error, no request even after realignment
    vecs.push_back(mk(1, 32'h6, 0,0,32'h0, 1,0, 0,0,0,0, 32'h0, 32'hA, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h6, 0,0,32'h0, 1,0, 0,0,0,1, 32'h0, 32'hA, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h8, 0,0,32'h0, 1,0, 0,0,0,1, 32'h0, 32'hC, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h8, 0,0,32'h0, 1,0, 0,0,0,1, 32'h0, 32'hC, 32'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rstBefore) doReset(v.fa);
      @(negedge clk);
      fetch_addr = v.fa; mem_gnt = v.gnt; mem_rvalid = v.rvalid; mem_rdata = v.rdata;
      inst_ready = v.ready; flush = v.fl;
      #1;
      check($sformatf("row%0d mem_req", i), mem_req, v.expReq);
      check($sformatf("row%0d pc_update", i), pc_update, v.expUpd);
      check($sformatf("row%0d inst_valid", i), inst_valid, v.expValid);
      check($sformatf("row%0d misalign_err", i), misalign_err, v.expErr);
      check($sformatf("row%0d mem_addr", i), mem_addr, v.expAddr);
      check($sformatf("row%0d next_pc", i), next_pc, v.expNext);
      if (v.expValid) begin
        check($sformatf("row%0d inst_pc", i), inst_pc, v.expPc);
        check($sformatf("row%0d inst_data", i), inst_data, v.expData);
      end
    end

    // decode stalled: only FIFO_DEPTH fetches accepted, then drained in order
    doReset(32'h0);
    gntPrev = 1'b0; pcAdv = 1'b0; gntAddr = '0; pcNext = '0; grants = 0;
    repeat (12) autoStep(1'b0);
    check("stall grants", grants, 2);
    check("stall mem_req", mem_req, 1'b0);
    check("stall inst_valid", inst_valid, 1'b1);
    nPop = 0; seenReq = 1'b0; reqAddr = '0;
    for (int k = 0; k < 8; k++) begin
      autoStep(1'b1);
      if (inst_valid && nPop < 2) begin
        popPc[nPop] = inst_pc;
        popData[nPop] = inst_data;
        nPop++;
      end
      if (mem_req && !seenReq) begin
        seenReq = 1'b1;
        reqAddr = mem_addr;
      end
    end
    check("drain count", nPop, 2);
    check("drain pc0", popPc[0], 32'h0);
    check("drain data0", popData[0], 32'hA5A50000);
    check("drain pc1", popPc[1], 32'h4);
    check("drain data1", popData[1], 32'hA5A50004);
    check("resume seen", seenReq, 1'b1);
    check("resume addr", reqAddr, 32'h8);

    // asynchronous reset while a read is outstanding with one word buffered
    doReset(32'h0);
    gntPrev = 1'b0; pcAdv = 1'b0; gntAddr = '0; pcNext = '0;
    repeat (5) autoStep(1'b0);
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("pre-reset inst_valid", inst_valid, 1'b1);
    check("pre-reset mem_req", mem_req, 1'b0);
    rst = 1'b1;
    #1;
    check("async mem_req", mem_req, 1'b0);
    check("async pc_update", pc_update, 1'b0);
    check("async inst_valid", inst_valid, 1'b0);
    check("async misalign_err", misalign_err, 1'b0);
    check("async mem_addr", mem_addr, 32'h0);
    check("async inst_pc", inst_pc, 32'h0);
    check("async inst_data", inst_data, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777; inst_ready = 1'b0;
    #1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check("stray rvalid inst_valid", inst_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter register.
- Takes the current instruction address, issues one read at a time to instruction memory, and buffers returned words with their PC in a small FIFO for decode.
- Drives the PC register's update strobe and sequential next address (PC+4), so the PC advances only when a fetch is accepted by memory.
- Redirect/flush input discards buffered and in-flight instructions.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
PC_STEP, 4, byte increment between sequential instructions

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
fetch_addr  in  ADDR_W  current PC from program counter register
next_pc  out  ADDR_W  fetch_addr + PC_STEP, to PC register address input
pc_update  out  1  one-cycle strobe, to PC register control input
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  read address
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
flush  in  1  discard buffered and in-flight fetches
inst_valid  out  1  instruction available to decode
inst_data  out  DATA_W  instruction word
inst_pc  out  ADDR_W  address of inst_data
inst_ready  in  1  decode accepts instruction
misalign_err  out  1  sticky: fetch_addr[1:0] != 0 seen when issuing

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; mem_req=0, pc_update=0, inst_valid=0, misalign_err=0, mem_addr=0, inst_data=0, inst_pc=0. next_pc is combinational, always fetch_addr+PC_STEP mod 2^ADDR_W (0xFFFFFFFC -> 0x00000000).
- FSM states: IDLE, REQ, WAIT, DROP.
- Credit rule: issue allowed only when fifo_count + (state==WAIT) < FIFO_DEPTH. Overflow is therefore impossible.
- IDLE:
  - if credit, !flush and fetch_addr[1:0]==0: latch mem_addr=fetch_addr, go REQ.
  - if misaligned: set misalign_err, stay IDLE (no issue until reset).
- REQ:
  - mem_req=1 and mem_addr held stable until mem_gnt.
  - On mem_gnt && !flush: pc_update=1 for exactly that cycle; latch pending_pc=mem_addr; go WAIT.
  - On mem_gnt && flush: request counts as accepted; no pc_update; go DROP.
  - On flush without gnt: deassert next cycle; go IDLE.
- WAIT:
  - On mem_rvalid && !flush: push {pending_pc, mem_rdata}; go IDLE.
  - On flush: go DROP; if mem_rvalid in the same cycle, discard it and go IDLE instead.
- DROP: mem_req=0; on mem_rvalid, discard data and go IDLE. Flush while in DROP keeps DROP.
- Throughput: minimum 3 cycles per instruction with gnt and rvalid each one cycle after request (IDLE->REQ->WAIT->IDLE). Memory read latency >= 1 cycle after gnt; rvalid in the same cycle as gnt is not supported.
- FIFO:
  - inst_valid = !empty; inst_data/inst_pc come from the head entry, registered.
  - Pop on inst_valid && inst_ready; simultaneous push and pop allowed.
  - Pointers wrap modulo FIFO_DEPTH.
  - flush clears count and pointers at the clock edge; inst_valid=0 the cycle after flush, and a pop in the flush cycle is ignored.
- pc_update never asserts in a cycle where flush=1. The PC register's redirect source is external; flush and the redirect are applied together by the control unit.
- Reset mid-transaction: state returns to IDLE immediately. A late mem_rvalid after reset is ignored (only WAIT/DROP consume it).

Test Plan:
- Reset, fetch_addr=0x0, gnt/rvalid one cycle after each request, inst_ready=1 -> pc_update pulses with next_pc=0x4, then 0x8; decode sees inst_pc 0x0, 0x4, 0x8 with matching mem_rdata in order.
- inst_ready=0 with 3 instructions available -> exactly 2 (FIFO_DEPTH) accepted by memory, mem_req stays 0 afterward; raising inst_ready drains 0x0, 0x4, then fetch resumes at 0x8.
- flush asserted in WAIT at pc=0x10, response 0xDEADBEEF arrives 3 cycles later -> discarded, inst_valid stays 0, no pc_update during flush; next fetch uses the new fetch_addr=0x100.
- flush coincident with mem_gnt -> no pc_update, FSM enters DROP, following rvalid data not pushed.
- fetch_addr=0xFFFFFFFC -> next_pc=0x00000000, mem_addr=0xFFFFFFFC; fetch_addr=0x6 -> misalign_err=1, mem_req never asserts.
- rst asserted while in WAIT with 1 FIFO entry -> all outputs 0 immediately (asynchronous); stray rvalid the next cycle produces no inst_valid.
